// File: rtl/i2c_pkg.sv
// Shared types and frame constants for the I2C write master.
package i2c_pkg;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK_SLOT, STOP, GAP} state_t;

    typedef logic [1:0] quarter_t;

    localparam int BYTES_PER_XFER = 3;
    localparam int BITS_PER_BYTE  = 8;

    function automatic logic is_last_slot(input logic [1:0] slot);
        return slot == 2'(BYTES_PER_XFER - 1);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period divider: tick_o fires on the last count while enabled.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == W'(CLK_DIV - 1));

    // Free-running count while enabled, parked at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(CLK_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// I2C write engine: serialises {addr,rw} plus a 16-bit word, collecting ack slots.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV       = 125,
    parameter int IDLE_QUARTERS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rwi2c,
    input  logic [6:0]  addressi2c,
    input  logic [15:0] datai2c,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_oe,
    output logic        busy,
    output logic        transmitionOver,
    output logic        ACK
);

    state_t     state_q;
    quarter_t   quarter_q;
    logic [23:0] shift_q;
    logic       rw_q;
    logic       nack_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] slot_cnt_q;
    logic [7:0] gap_cnt_q;
    logic       scl_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_q;
    logic       tick_s;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .tick_o (tick_s)
    );

    assign scl             = scl_q;
    assign sda_oe          = sda_oe_q;
    assign busy            = busy_q;
    assign transmitionOver = done_q;
    assign ACK             = ack_q;

    // Frame sequencer: launch in IDLE, every other step advances on a quarter tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            quarter_q  <= 2'd0;
            shift_q    <= 24'd0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            slot_cnt_q <= 2'd0;
            gap_cnt_q  <= 8'd0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    shift_q    <= {addressi2c, rwi2c, datai2c};
                    rw_q       <= rwi2c;
                    nack_q     <= 1'b0;
                    bit_cnt_q  <= 3'd0;
                    slot_cnt_q <= 2'd0;
                    quarter_q  <= 2'd0;
                    busy_q     <= 1'b1;
                    state_q    <= START;
                end
            end else if (tick_s) begin
                quarter_q <= quarter_q + 2'd1;
                case (state_q)
                    START: begin
                        case (quarter_q)
                            2'd0:    begin scl_q <= 1'b1; sda_oe_q <= 1'b0; end
                            2'd1:    sda_oe_q <= 1'b1;
                            2'd3:    begin scl_q <= 1'b0; state_q <= BIT; end
                            default: ;
                        endcase
                    end
                    BIT: begin
                        case (quarter_q)
                            2'd0:    sda_oe_q <= ~shift_q[23];
                            2'd1:    scl_q <= 1'b1;
                            2'd3: begin
                                scl_q     <= 1'b0;
                                shift_q   <= {shift_q[22:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
                                    state_q <= ACK_SLOT;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ACK_SLOT: begin
                        case (quarter_q)
                            2'd0:    sda_oe_q <= 1'b0;
                            2'd1:    scl_q <= 1'b1;
                            2'd2:    if (sda_in) nack_q <= 1'b1;
                            2'd3: begin
                                scl_q <= 1'b0;
                                // A read request is cut short after its address byte.
                                if (nack_q || is_last_slot(slot_cnt_q) ||
                                    (slot_cnt_q == 2'd0 && rw_q)) begin
                                    state_q <= STOP;
                                    if (rw_q) nack_q <= 1'b1;
                                end else begin
                                    state_q    <= BIT;
                                    slot_cnt_q <= slot_cnt_q + 2'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    STOP: begin
                        case (quarter_q)
                            2'd0:    begin sda_oe_q <= 1'b1; scl_q <= 1'b0; end
                            2'd1:    scl_q <= 1'b1;
                            2'd2:    sda_oe_q <= 1'b0;
                            2'd3: begin
                                done_q    <= 1'b1;
                                ack_q     <= ~nack_q;
                                gap_cnt_q <= 8'd0;
                                state_q   <= GAP;
                            end
                            default: ;
                        endcase
                    end
                    GAP: begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                        if (gap_cnt_q == 8'(IDLE_QUARTERS - 1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master with a simple acking slave model.
module tb_i2c_write_master;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rwi2c = 1'b0;
    logic [6:0]  addressi2c = 7'd0;
    logic [15:0] datai2c = 16'd0;
    logic        sda_in;
    logic        scl, sda_oe, busy, transmitionOver, ACK;

    logic        slave_pull = 1'b0;
    int          nack_slot = 0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nbit = 0;
    int          pulses = 0;
    int          stop_cyc = 0;
    int          min_gap = 1000000;
    logic        have_stop = 1'b0;
    logic [7:0]  sh = 8'd0;
    logic [7:0]  bytes[$];
    logic        scl_p = 1'b1;
    logic        sda_p = 1'b1;

    assign sda_in = ~(sda_oe | slave_pull);

    i2c_write_master #(.CLK_DIV(CLK_DIV), .IDLE_QUARTERS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rwi2c(rwi2c),
        .addressi2c(addressi2c), .datai2c(datai2c), .sda_in(sda_in),
        .scl(scl), .sda_oe(sda_oe), .busy(busy),
        .transmitionOver(transmitionOver), .ACK(ACK)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and slave: decodes START/STOP, captures bytes, drives ack slots.
    always @(negedge clk) begin
        logic sda_l;
        sda_l = ~(sda_oe | slave_pull);
        if (transmitionOver) pulses++;
        if (scl_p && scl && sda_p && !sda_l) begin
            nbit = 0;
            if (have_stop && (cyc - stop_cyc) < min_gap) min_gap = cyc - stop_cyc;
        end else if (scl_p && scl && !sda_p && sda_l) begin
            stop_cyc  = cyc;
            have_stop = 1'b1;
        end
        if (!scl_p && scl) begin
            nbit++;
            if (nbit % 9 != 0) begin
                sh = {sh[6:0], sda_l};
                if (nbit % 9 == 8) bytes.push_back(sh);
            end
        end
        if (scl_p && !scl) begin
            if (nbit % 9 == 8) slave_pull = (nack_slot != (nbit / 9 + 1));
            else slave_pull = 1'b0;
        end
        scl_p = scl;
        sda_p = ~(sda_oe | slave_pull);
    end

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [15:0] data;
        int          nack;
        logic        mutate;
        int          nbytes;
        logic [7:0]  b[3];
        logic        ack;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_pulse(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (transmitionOver) begin ok = 1'b1; break; end
        end
        check({nm, " pulse_seen"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int launch_cyc, lat, exp_lat;
        wait_idle();
        bytes.delete();
        nack_slot  = v.nack;
        rwi2c      = v.rw;
        addressi2c = v.addr;
        datai2c    = v.data;
        start      = 1'b1;
        launch_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        if (v.mutate) datai2c = ~v.data;
        check({nm, " busy_rise"}, {31'd0, busy}, 32'd1);
        wait_pulse(nm);
        lat     = cyc - launch_cyc;
        exp_lat = (8 + 36 * v.nbytes) * CLK_DIV;
        tests++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d +-1", nm, lat, exp_lat);
        end
        check({nm, " ack"}, {31'd0, ACK}, {31'd0, v.ack});
        @(negedge clk);
        check({nm, " pulse_width"}, {31'd0, transmitionOver}, 32'd0);
        check({nm, " nbytes"}, bytes.size(), v.nbytes);
        for (int i = 0; i < v.nbytes && i < bytes.size(); i++)
            check($sformatf("%s byte%0d", nm, i), {24'd0, bytes[i]}, {24'd0, v.b[i]});
    endtask

    initial begin
        logic [15:0] rep[7];
        int p0;

        vecs[0] = '{1'b0, 7'h1A, 16'h1E00, 0, 1'b0, 3, '{8'h34, 8'h1E, 8'h00}, 1'b1};
        vecs[1] = '{1'b0, 7'h1A, 16'h1E00, 2, 1'b0, 2, '{8'h34, 8'h1E, 8'h00}, 1'b0};
        vecs[2] = '{1'b1, 7'h1A, 16'h1E00, 0, 1'b0, 1, '{8'h35, 8'h00, 8'h00}, 1'b0};
        vecs[3] = '{1'b0, 7'h7F, 16'hA5C3, 1, 1'b0, 1, '{8'hFE, 8'h00, 8'h00}, 1'b0};
        vecs[4] = '{1'b0, 7'h00, 16'hFFFF, 0, 1'b1, 3, '{8'h00, 8'hFF, 8'hFF}, 1'b1};
        vecs[5] = '{1'b0, 7'h50, 16'h1234, 3, 1'b0, 3, '{8'hA0, 8'h12, 8'h34}, 1'b0};
        rep = '{16'h1E00, 16'h1201, 16'h0C02, 16'h0A03, 16'h0E04, 16'h1005, 16'h0815};

        repeat (3) @(negedge clk);
        check("reset scl", {31'd0, scl}, 32'd1);
        check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset pulse", {31'd0, transmitionOver}, 32'd0);
        check("reset ack", {31'd0, ACK}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // start held high: seven frames, data advanced on each completion
        wait_idle();
        bytes.delete();
        nack_slot  = 0;
        have_stop  = 1'b0;
        min_gap    = 1000000;
        p0         = pulses;
        rwi2c      = 1'b0;
        addressi2c = 7'h1A;
        datai2c    = rep[0];
        start      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_pulse($sformatf("rep%0d", i));
            check($sformatf("rep%0d ack", i), {31'd0, ACK}, 32'd1);
            if (i < 6) datai2c = rep[i + 1];
            else start = 1'b0;
            @(negedge clk);
        end
        check("rep pulses", pulses - p0, 7);
        check("rep nbytes", bytes.size(), 21);
        for (int i = 0; i < 7 && 3 * i + 2 < bytes.size(); i++) begin
            check($sformatf("rep%0d b0", i), {24'd0, bytes[3*i]},   32'h34);
            check($sformatf("rep%0d b1", i), {24'd0, bytes[3*i+1]}, {24'd0, rep[i][15:8]});
            check($sformatf("rep%0d b2", i), {24'd0, bytes[3*i+2]}, {24'd0, rep[i][7:0]});
        end
        tests++;
        if (min_gap < 8 * CLK_DIV) begin
            fails++;
            $display("FAIL rep gap: got %0d clocks expected >= %0d", min_gap, 8 * CLK_DIV);
        end

        // asynchronous reset in the middle of the second byte
        wait_idle();
        nack_slot  = 0;
        rwi2c      = 1'b0;
        addressi2c = 7'h1A;
        datai2c    = 16'h1E00;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && nbit < 12; i++) @(negedge clk);
        check("midrst reached byte2", {31'd0, (nbit >= 12)}, 32'd1);
        p0 = pulses;
        #1 rst = 1'b1;
        #1;
        check("midrst scl", {31'd0, scl}, 32'd1);
        check("midrst sda_oe", {31'd0, sda_oe}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst no pulse", pulses - p0, 0);
        run_vec(vecs[0], "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
